// File: rtl/ysyx_25020037_rd_arbiter.sv
// Round-robin AXI4 read arbiter: IFU/LSU share one downstream read port; one-entry AR slice, grant held per burst.
// AR adds one cycle; R is a combinational pass-through with beat/ID checks feeding a sticky err flag.
module ysyx_25020037_rd_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [31:0] ifu_araddr,
  input  logic [3:0]  ifu_arid,
  input  logic [7:0]  ifu_arlen,
  input  logic [2:0]  ifu_arsize,
  input  logic [1:0]  ifu_arburst,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rlast,
  output logic [3:0]  ifu_rid,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  input  logic [31:0] lsu_araddr,
  input  logic [3:0]  lsu_arid,
  input  logic [7:0]  lsu_arlen,
  input  logic [2:0]  lsu_arsize,
  input  logic [1:0]  lsu_arburst,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rlast,
  output logic [3:0]  lsu_rid,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic [3:0]  m_rid,
  output logic        grant_lsu,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_RDATA} state_e;

  state_e      state_q, state_d;
  logic        last_lsu_q, last_lsu_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic        err_q, err_d;

  logic win_lsu;
  logic rready_sel;
  logic up_rlast;
  logic beat_at_len;

  // On contention the master that was not served last wins.
  assign win_lsu     = lsu_arvalid & (~ifu_arvalid | ~last_lsu_q);
  assign rready_sel  = owner_q ? lsu_rready : ifu_rready;
  assign beat_at_len = (beat_q == len_q);
  assign up_rlast    = m_rlast | beat_at_len;

  always_comb begin
    state_d    = state_q;
    last_lsu_d = last_lsu_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    id_d       = id_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    m_arvalid  = 1'b0;
    m_araddr   = 32'd0;
    m_arid     = 4'd0;
    m_arlen    = 8'd0;
    m_arsize   = 3'd0;
    m_arburst  = 2'd0;
    m_rready   = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = 32'd0;
    ifu_rresp  = 2'd0;
    ifu_rlast  = 1'b0;
    ifu_rid    = 4'd0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = 32'd0;
    lsu_rresp  = 2'd0;
    lsu_rlast  = 1'b0;
    lsu_rid    = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (win_lsu) begin
          lsu_arready = 1'b1;
          owner_d     = 1'b1;
          addr_d      = lsu_araddr;
          id_d        = lsu_arid;
          len_d       = lsu_arlen;
          size_d      = lsu_arsize;
          burst_d     = lsu_arburst;
          state_d     = S_AR;
        end else if (ifu_arvalid) begin
          ifu_arready = 1'b1;
          owner_d     = 1'b0;
          addr_d      = ifu_araddr;
          id_d        = ifu_arid;
          len_d       = ifu_arlen;
          size_d      = ifu_arsize;
          burst_d     = ifu_arburst;
          state_d     = S_AR;
        end
      end
      S_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = addr_q;
        m_arid    = id_q;
        m_arlen   = len_q;
        m_arsize  = size_q;
        m_arburst = burst_q;
        if (m_arready) begin
          beat_d  = 8'd0;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        m_rready = rready_sel;
        if (owner_q) begin
          lsu_rvalid = m_rvalid;
          lsu_rdata  = m_rdata;
          lsu_rresp  = m_rresp;
          lsu_rlast  = up_rlast;
          lsu_rid    = m_rid;
        end else begin
          ifu_rvalid = m_rvalid;
          ifu_rdata  = m_rdata;
          ifu_rresp  = m_rresp;
          ifu_rlast  = up_rlast;
          ifu_rid    = m_rid;
        end
        if (m_rvalid && rready_sel) begin
          beat_d = beat_q + 8'd1;
          // Early/missing m_rlast or a foreign ID is flagged, but the burst still ends normally.
          if ((m_rlast != beat_at_len) || (m_rid != id_q)) begin
            err_d = 1'b1;
          end
          if (up_rlast) begin
            last_lsu_d = owner_q;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_lsu_q <= 1'b0;
      owner_q    <= 1'b0;
      addr_q     <= 32'd0;
      id_q       <= 4'd0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      beat_q     <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

  assign grant_lsu = owner_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ysyx_25020037_rd_arbiter.sv
// Randomized bench for the IFU/LSU read arbiter with a transaction-level reference model.
module tb_ysyx_25020037_rd_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [3:0]  ifu_arid, ifu_rid;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst, ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [3:0]  lsu_arid, lsu_rid;
  logic [7:0]  lsu_arlen;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_arburst, lsu_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        grant_lsu, err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: who was served last (1 = LSU) and the expected sticky error.
  bit last_lsu_m = 1'b0;
  bit err_m      = 1'b0;

  ysyx_25020037_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .grant_lsu(grant_lsu), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read burst. pat: 1 = IFU only, 2 = LSU only, 3 = both request.
  // slave_last: beat index on which the slave raises m_rlast (> len means never).
  task automatic xact(input int pat, input logic [31:0] addr, input logic [7:0] len,
                      input logic [3:0] id, input int slave_last, input bit bad_rid,
                      input bit stall, input logic [31:0] base);
    bit win;
    int nend;
    logic [31:0] d;
    win  = (pat == 2) ? 1'b1 : (pat == 1) ? 1'b0 : !last_lsu_m;
    nend = (slave_last < int'(len)) ? slave_last : int'(len);

    ifu_arvalid = (pat != 2);
    lsu_arvalid = (pat != 1);
    if (win) begin
      lsu_araddr = addr;  lsu_arid = id;        lsu_arlen = len;        lsu_arsize = 3'd2; lsu_arburst = 2'b01;
      ifu_araddr = ~addr; ifu_arid = id + 4'd1; ifu_arlen = len + 8'd1; ifu_arsize = 3'd1; ifu_arburst = 2'b10;
    end else begin
      ifu_araddr = addr;  ifu_arid = id;        ifu_arlen = len;        ifu_arsize = 3'd2; ifu_arburst = 2'b01;
      lsu_araddr = ~addr; lsu_arid = id + 4'd1; lsu_arlen = len + 8'd1; lsu_arsize = 3'd1; lsu_arburst = 2'b10;
    end
    #1;
    chk("arready_winner", win ? lsu_arready : ifu_arready, 1);
    chk("arready_loser", win ? ifu_arready : lsu_arready, 0);
    tick();
    if (win) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    #1;
    chk("m_arvalid", m_arvalid, 1);
    chk("m_araddr", m_araddr, addr);
    chk("m_arid", m_arid, id);
    chk("m_arlen", m_arlen, len);
    chk("m_arsize", m_arsize, 2);
    chk("m_arburst", m_arburst, 1);
    chk("grant_lsu", grant_lsu, win);
    chk("arready_in_ar", ifu_arready | lsu_arready, 0);
    chk("m_rready_in_ar", m_rready, 0);
    if (stall) begin
      repeat (2) begin
        tick();
        chk("ar_hold_valid", m_arvalid, 1);
        chk("ar_hold_addr", m_araddr, addr);
      end
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    #1;
    chk("m_arvalid_after_hs", m_arvalid, 0);

    for (int b = 0; b <= nend; b++) begin
      if (stall) begin
        m_rvalid = 1'b0;
        repeat (2) begin
          tick();
          chk("gap_rvalid", win ? lsu_rvalid : ifu_rvalid, 0);
        end
        if (b == 1) begin
          m_rvalid = 1'b1; m_rdata = 32'hBAD0_0000; m_rid = id; m_rlast = 1'b0;
          if (win) lsu_rready = 1'b0; else ifu_rready = 1'b0;
          #1;
          chk("drop_m_rready", m_rready, 0);
          chk("drop_rvalid", win ? lsu_rvalid : ifu_rvalid, 1);
          tick();
        end
      end
      d = base + b * 32'h0101_0101;
      m_rvalid = 1'b1;
      m_rdata  = d;
      m_rresp  = 2'(b);
      m_rid    = bad_rid ? (id ^ 4'h6) : id;
      m_rlast  = (b == slave_last);
      if (win) begin lsu_rready = 1'b1; ifu_rready = 1'($urandom_range(0, 1)); end
      else     begin ifu_rready = 1'b1; lsu_rready = 1'($urandom_range(0, 1)); end
      #1;
      chk("rvalid", win ? lsu_rvalid : ifu_rvalid, 1);
      chk("rdata", win ? lsu_rdata : ifu_rdata, d);
      chk("rresp", win ? lsu_rresp : ifu_rresp, 32'(b % 4));
      chk("rid", win ? lsu_rid : ifu_rid, bad_rid ? (id ^ 4'h6) : id);
      chk("rlast", win ? lsu_rlast : ifu_rlast, (b == nend));
      chk("loser_rvalid", win ? ifu_rvalid : lsu_rvalid, 0);
      chk("loser_rdata", win ? ifu_rdata : lsu_rdata, 0);
      chk("loser_arready", ifu_arready | lsu_arready, 0);
      chk("m_rready", m_rready, 1);
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
    err_m      = err_m | (slave_last != int'(len)) | bad_rid;
    last_lsu_m = win;
    #1;
    chk("err", err, err_m);
    chk("m_rready_idle", m_rready, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 0; ifu_arlen = 0; ifu_arsize = 0; ifu_arburst = 0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_arburst = 0; lsu_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rid = 0;
    #2;
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_rvalid", ifu_rvalid | lsu_rvalid, 0);
    chk("rst_arready", ifu_arready | lsu_arready, 0);
    chk("rst_err", err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    xact(1, 32'h3000_0000, 8'd0, 4'h2, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++)
      xact(3, 32'h8000_0000 + i * 16, 8'(i % 3), 4'(i), i % 3, 1'b0, 1'b0, $urandom);
    xact(2, 32'h8000_1000, 8'd3, 4'h7, 3, 1'b0, 1'b1, 32'h1111_0000);
    xact(1, 32'h8000_2000, 8'd3, 4'h4, 1, 1'b0, 1'b0, 32'h2222_0000);
    xact(2, 32'h8000_3000, 8'd1, 4'h1, 1, 1'b0, 1'b0, 32'h3333_0000);
    xact(1, 32'h8000_4000, 8'd1, 4'h3, 1, 1'b1, 1'b0, 32'h4444_0000);

    for (int i = 0; i < 40; i++) begin
      int pat, ln, sl;
      pat = $urandom_range(1, 3);
      ln  = $urandom_range(0, 7);
      sl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ln + 1) : ln;
      xact(pat, $urandom, 8'(ln), 4'($urandom), sl, ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), $urandom);
    end
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    tick();

    // Reset in the middle of a burst, on its second beat.
    ifu_arvalid = 1'b1; ifu_araddr = 32'h9000_0000; ifu_arid = 4'h9; ifu_arlen = 8'd3;
    ifu_arsize = 3'd2; ifu_arburst = 2'b01;
    tick();
    ifu_arvalid = 1'b0; m_arready = 1'b1;
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0; m_rid = 4'h9; ifu_rready = 1'b1;
    tick();
    m_rdata = 32'h1;
    #1;
    chk("pre_rst_rvalid", ifu_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", ifu_rvalid | lsu_rvalid, 0);
    chk("mid_rst_m_rready", m_rready, 0);
    chk("mid_rst_m_arvalid", m_arvalid, 0);
    chk("mid_rst_arready", ifu_arready | lsu_arready, 0);
    chk("mid_rst_err", err, 0);
    m_rvalid = 1'b0; ifu_rready = 1'b0;
    tick();
    rst_n = 1'b1;
    err_m = 1'b0; last_lsu_m = 1'b0;
    tick();
    xact(1, 32'h3000_0040, 8'd1, 4'h5, 1, 1'b0, 1'b0, 32'hCAFE_0000);
    xact(3, 32'h3000_0080, 8'd0, 4'h6, 0, 1'b0, 1'b0, 32'h5555_0000);
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
